reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 22 ++
 rtl/sync_bit.sv | 21 ++
 rtl/reset_sequencer.sv | 141 ++++++++++++++
 tb/tb_reset_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: reset-cause codes, sequencer states
// and a counter-width helper that keeps degenerate parameter values legal.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    POR = 2'd0,
    EXT = 2'd1,
    WDT = 2'd2,
    SW  = 2'd3
  } rst_cause_e;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level, cleared by the
// synchronous active-high reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (reset) r_chain <= '0;
    else       r_chain <= {r_chain[STAGES-2:0], i_async};
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-source reset controller: stretches reset, releases domains in index
// order with a fixed gap, and records why the last reset happened.
//   state   | meaning
//   HOLD    | all domains in reset, counting request-free cycles
//   RELEASE | domains being released one every STAGE_GAP cycles
//   RUN     | all domains out of reset, watchdog active
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 2,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int WDT_EN      = 1,
  parameter int WDT_CYCLES  = 1000000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ext_rst_req,
  input  logic                   sw_rst_req,
  input  logic                   wdt_kick,
  output logic [NUM_DOMAINS-1:0] reset_n_out,
  output logic [1:0]             rst_cause,
  output logic                   busy
);

  localparam int HOLD_W = cnt_width(HOLD_CYCLES);
  localparam int GAP_W  = cnt_width(STAGE_GAP);
  localparam int WDT_W  = cnt_width(WDT_CYCLES);

  localparam logic [HOLD_W-1:0]      HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [GAP_W-1:0]       GAP_LAST   = GAP_W'(STAGE_GAP - 1);
  localparam logic [WDT_W-1:0]       WDT_LAST   = WDT_W'(WDT_CYCLES - 1);
  localparam logic [3:0]             LAST_STAGE = 4'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE    = NUM_DOMAINS'(1);

  state_e                 r_state;
  rst_cause_e             r_cause;
  logic [HOLD_W-1:0]      r_hold;
  logic [GAP_W-1:0]       r_gap;
  logic [3:0]             r_stage;
  logic [NUM_DOMAINS-1:0] r_rst_n;
  logic                   r_busy;

  logic       w_ext_req;
  logic       w_wdt_expire;
  logic       w_any_req;
  rst_cause_e w_req_cause;

  sync_bit #(.STAGES(SYNC_STAGES)) u_ext_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (ext_rst_req),
    .o_sync  (w_ext_req)
  );

  assign w_any_req   = w_ext_req | sw_rst_req | w_wdt_expire;
  assign w_req_cause = w_ext_req ? EXT : (w_wdt_expire ? WDT : SW);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HOLD;
      r_cause <= POR;
      r_hold  <= '0;
      r_gap   <= '0;
      r_stage <= '0;
      r_rst_n <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        HOLD: begin
          // Requests here only stretch the hold; the recorded cause stays.
          if (w_ext_req || sw_rst_req) begin
            r_hold <= '0;
          end else if (r_hold == HOLD_LAST) begin
            r_rst_n <= DOM_ONE;
            r_gap   <= '0;
            r_stage <= 4'd1;
            if (NUM_DOMAINS == 1) begin
              r_state <= RUN;
              r_busy  <= 1'b0;
            end else begin
              r_state <= RELEASE;
            end
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        RELEASE, RUN: begin
          if (w_any_req) begin
            r_state <= HOLD;
            r_cause <= w_req_cause;
            r_hold  <= '0;
            r_rst_n <= '0;
            r_busy  <= 1'b1;
          end else if (r_state == RELEASE) begin
            if (r_gap == GAP_LAST) begin
              r_gap   <= '0;
              r_rst_n <= (r_rst_n << 1) | DOM_ONE;
              if (r_stage == LAST_STAGE) begin
                r_state <= RUN;
                r_busy  <= 1'b0;
              end else begin
                r_stage <= r_stage + 4'd1;
              end
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
        end
        default: begin
          r_state <= HOLD;
          r_hold  <= '0;
          r_rst_n <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  generate
    if (WDT_EN != 0) begin : g_wdt
      logic [WDT_W-1:0] r_wdt;

      // Saturates at the terminal value; a kick on the expiry cycle wins.
      always_ff @(posedge clk) begin
        if (reset || r_state != RUN || wdt_kick || w_any_req) r_wdt <= '0;
        else if (r_wdt != WDT_LAST)                           r_wdt <= r_wdt + 1'b1;
      end

      assign w_wdt_expire = (r_state == RUN) && (r_wdt == WDT_LAST) && !wdt_kick;
    end else begin : g_no_wdt
      assign w_wdt_expire = 1'b0;
    end
  endgenerate

  assign reset_n_out = r_rst_n;
  assign rst_cause   = r_cause;
  assign busy        = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: randomised requests and kicks checked against a
// timing-level model (release edges derived from the start of the last quiet hold).
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int N    = 4;
  localparam int SS   = 2;
  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int WDTC = 100;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ext_rst_req = 1'b0;
  logic         sw_rst_req = 1'b0;
  logic         wdt_kick = 1'b0;
  logic [N-1:0] reset_n_out;
  logic [1:0]   rst_cause;
  logic         busy;

  reset_sequencer #(
    .NUM_DOMAINS (N),
    .SYNC_STAGES (SS),
    .HOLD_CYCLES (HOLD),
    .STAGE_GAP   (GAP),
    .WDT_EN      (1),
    .WDT_CYCLES  (WDTC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ext_rst_req (ext_rst_req),
    .sw_rst_req  (sw_rst_req),
    .wdt_kick    (wdt_kick),
    .reset_n_out (reset_n_out),
    .rst_cause   (rst_cause),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: t0 is the first edge of the current quiet hold; domain i rises
  // on edge t0+HOLD-1+i*GAP. Watchdog fires WDTC edges after the later of
  // RUN entry and the last kick.
  longint       t = 0;
  longint       last_edge = 0;
  longint       t0 = 1;
  longint       last_kick = -1;
  logic [1:0]   m_cause = 2'd0;
  logic [SS-1:0] m_sync = '0;
  logic [N-1:0] exp_rst_n = '0;
  logic         exp_busy = 1'b1;

  task automatic tick();
    logic   ext_q;
    logic   wdt_exp;
    longint rel0, run_e, svc;
    ext_q = m_sync[SS-1];
    rel0  = t0 + HOLD - 1;
    run_e = rel0 + (N - 1) * GAP;
    if (reset) begin
      t0      = t + 1;
      m_cause = 2'd0;
      m_sync  = '0;
    end else begin
      svc     = (last_kick > run_e) ? last_kick : run_e;
      wdt_exp = (t > run_e) && !wdt_kick && (t == svc + WDTC);
      if (t <= rel0) begin
        if (ext_q || sw_rst_req) t0 = t + 1;
      end else if (ext_q || sw_rst_req || wdt_exp) begin
        t0      = t + 1;
        m_cause = ext_q ? 2'd1 : (wdt_exp ? 2'd2 : 2'd3);
      end
      if (wdt_kick) last_kick = t;
      m_sync = {m_sync[SS-2:0], ext_rst_req};
    end
    for (int i = 0; i < N; i++) exp_rst_n[i] = (t >= t0 + HOLD - 1 + i * GAP);
    exp_busy = (t < t0 + HOLD - 1 + (N - 1) * GAP);
    @(posedge clk);
    #1;
    last_edge = t;
    t++;
  endtask

  function automatic logic keepalive();
    return ((t % 37) == 0) || ($urandom_range(0, 9) == 0);
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sw_rst_req = 1'($urandom_range(0, 1));
      wdt_kick   = 1'($urandom_range(0, 1));
      tick();
    end
    sw_rst_req = 1'b0;
    wdt_kick   = 1'b0;
    checks++;
    if (reset_n_out !== 4'b0000) begin errors++; $display("FAIL reset_rst_n got %b want 0000", reset_n_out); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
    checks++;
    if (rst_cause !== 2'd0) begin errors++; $display("FAIL reset_cause got %0d want 0", rst_cause); end
  endtask

  task automatic test_por_release();
    longint base, e;
    reset = 1'b0;
    base  = t;
    for (int k = 0; k < 40; k++) begin
      tick();
      e = last_edge - base;
      checks++;
      if ({reset_n_out, busy, rst_cause} !== {exp_rst_n, exp_busy, m_cause}) begin
        errors++;
        $display("FAIL por_seq edge %0d got %b/%b/%0d want %b/%b/%0d", e, reset_n_out, busy, rst_cause, exp_rst_n, exp_busy, m_cause);
      end
      if (e == 14 || e == 15 || e == 19 || e == 27) begin
        logic [N-1:0] want;
        want = (e == 14) ? 4'b0000 : (e == 15) ? 4'b0001 : (e == 19) ? 4'b0011 : 4'b1111;
        checks++;
        if (reset_n_out !== want || busy !== (e != 27)) begin
          errors++;
          $display("FAIL por_edge%0d got %b busy %b want %b busy %b", e, reset_n_out, busy, want, e != 27);
        end
      end
    end
  endtask

  task automatic test_sw_reset();
    longint e;
    for (int it = 0; it < 3; it++) begin
      for (int k = 0, n = $urandom_range(5, 30); k < n; k++) begin
        wdt_kick = keepalive();
        tick();
        checks++;
        if ({reset_n_out, busy, rst_cause} !== {exp_rst_n, exp_busy, m_cause}) begin
          errors++;
          $display("FAIL sw_run edge %0d got %b/%b/%0d want %b/%b/%0d", last_edge, reset_n_out, busy, rst_cause, exp_rst_n, exp_busy, m_cause);
        end
      end
      wdt_kick   = 1'b0;
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
      e = last_edge;
      checks++;
      if ({reset_n_out, busy, rst_cause} !== {4'b0000, 1'b1, 2'd3}) begin
        errors++;
        $display("FAIL sw_enter got %b/%b/%0d want 0000/1/3", reset_n_out, busy, rst_cause);
      end
      for (int k = 0; k < 30; k++) begin
        wdt_kick = keepalive();
        tick();
        checks++;
        if ({reset_n_out, busy, rst_cause} !== {exp_rst_n, exp_busy, m_cause}) begin
          errors++;
          $display("FAIL sw_seq edge %0d got %b/%b/%0d want %b/%b/%0d", last_edge, reset_n_out, busy, rst_cause, exp_rst_n, exp_busy, m_cause);
        end
        if (last_edge == e + 15 || last_edge == e + 16) begin
          checks++;
          if (reset_n_out[0] !== (last_edge == e + 16)) begin
            errors++;
            $display("FAIL sw_rerelease +%0d got %b want %b", last_edge - e, reset_n_out[0], last_edge == e + 16);
          end
        end
      end
    end
  endtask

  task automatic test_ext_stretch();
    longint d;
    for (int it = 0; it < 2; it++) begin
      int len;
      len = (it == 0) ? 40 : $urandom_range(5, 40);
      ext_rst_req = 1'b1;
      for (int k = 0; k < len; k++) begin
        wdt_kick = keepalive();
        tick();
        checks++;
        if ({reset_n_out, busy, rst_cause} !== {exp_rst_n, exp_busy, m_cause}) begin
          errors++;
          $display("FAIL ext_hold edge %0d got %b/%b/%0d want %b/%b/%0d", last_edge, reset_n_out, busy, rst_cause, exp_rst_n, exp_busy, m_cause);
        end
        if (k == 1 || k == 2) begin
          checks++;
          if (reset_n_out !== ((k == 1) ? 4'b1111 : 4'b0000) || (k == 2 && rst_cause !== 2'd1)) begin
            errors++;
            $display("FAIL ext_latency k=%0d got %b cause %0d", k, reset_n_out, rst_cause);
          end
        end
      end
      ext_rst_req = 1'b0;
      d = t;
      for (int k = 0; k < 35; k++) begin
        wdt_kick = keepalive();
        tick();
        checks++;
        if ({reset_n_out, busy, rst_cause} !== {exp_rst_n, exp_busy, m_cause}) begin
          errors++;
          $display("FAIL ext_rel edge %0d got %b/%b/%0d want %b/%b/%0d", last_edge, reset_n_out, busy, rst_cause, exp_rst_n, exp_busy, m_cause);
        end
        if (last_edge == d + 16 || last_edge == d + 17) begin
          checks++;
          if (reset_n_out[0] !== (last_edge == d + 17)) begin
            errors++;
            $display("FAIL ext_release +%0d got %b want %b", last_edge - d, reset_n_out[0], last_edge == d + 17);
          end
        end
      end
    end
  endtask

  task automatic test_watchdog();
    longint r, x;
    int rises;
    wdt_kick   = 1'b0;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    r = -1;
    x = -1;
    for (int k = 0; k < 200 && x < 0; k++) begin
      tick();
      checks++;
      if ({reset_n_out, busy, rst_cause} !== {exp_rst_n, exp_busy, m_cause}) begin
        errors++;
        $display("FAIL wdt_free edge %0d got %b/%b/%0d want %b/%b/%0d", last_edge, reset_n_out, busy, rst_cause, exp_rst_n, exp_busy, m_cause);
      end
      if (r < 0 && busy === 1'b0) r = last_edge;
      else if (r >= 0 && busy === 1'b1) x = last_edge;
    end
    checks++;
    if (r < 0 || x - r != WDTC || rst_cause !== 2'd2) begin
      errors++;
      $display("FAIL wdt_expiry run-to-reset %0d edges cause %0d want %0d edges cause 2", x - r, rst_cause, WDTC);
    end
    for (int k = 0; k < 30; k++) tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wdt_rerun busy %b want 0", busy); end
    rises = 0;
    r = t;
    for (int k = 0; k < 1000; k++) begin
      wdt_kick = (((t - r) % 50) == 0);
      tick();
      if (busy !== 1'b0) rises++;
    end
    wdt_kick = 1'b0;
    checks++;
    if (rises != 0) begin errors++; $display("FAIL wdt_kick50 busy cycles %0d want 0", rises); end
    wdt_kick = 1'b1;
    tick();
    for (int j = 0; j < 6; j++) begin
      int gap;
      gap = (j == 4) ? 100 : (j == 5) ? 101 : $urandom_range(90, 100);
      for (int c = 1; c <= gap; c++) begin
        wdt_kick = (c == gap);
        tick();
        checks++;
        if ({reset_n_out, busy, rst_cause} !== {exp_rst_n, exp_busy, m_cause}) begin
          errors++;
          $display("FAIL wdt_edge gap %0d edge %0d got %b/%b/%0d want %b/%b/%0d", gap, last_edge, reset_n_out, busy, rst_cause, exp_rst_n, exp_busy, m_cause);
        end
      end
      wdt_kick = 1'b0;
      checks++;
      if (busy !== (gap > 100) || (gap > 100 && rst_cause !== 2'd2)) begin
        errors++;
        $display("FAIL wdt_boundary gap %0d busy %b cause %0d want busy %b", gap, busy, rst_cause, gap > 100);
      end
    end
  endtask

  task automatic test_simultaneous();
    longint s;
    for (int k = 0; k < 40; k++) begin
      wdt_kick = keepalive();
      tick();
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL sim_prerun busy %b want 0", busy); end
    wdt_kick    = 1'b0;
    ext_rst_req = 1'b1;
    tick();
    tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    checks++;
    if (rst_cause !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sim_priority cause %0d busy %b want 1/1", rst_cause, busy);
    end
    for (int k = 0, n = $urandom_range(2, 6); k < n; k++) tick();
    ext_rst_req = 1'b0;
    for (int k = 0, n = $urandom_range(3, 12); k < n; k++) begin
      tick();
      checks++;
      if ({reset_n_out, busy, rst_cause} !== {exp_rst_n, exp_busy, m_cause}) begin
        errors++;
        $display("FAIL sim_hold edge %0d got %b/%b/%0d want %b/%b/%0d", last_edge, reset_n_out, busy, rst_cause, exp_rst_n, exp_busy, m_cause);
      end
    end
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    s = last_edge;
    for (int k = 0; k < 30; k++) begin
      wdt_kick = keepalive();
      tick();
      checks++;
      if ({reset_n_out, busy, rst_cause} !== {exp_rst_n, exp_busy, m_cause}) begin
        errors++;
        $display("FAIL sim_stretch edge %0d got %b/%b/%0d want %b/%b/%0d", last_edge, reset_n_out, busy, rst_cause, exp_rst_n, exp_busy, m_cause);
      end
      if (last_edge == s + 15 || last_edge == s + 16) begin
        checks++;
        if (reset_n_out[0] !== (last_edge == s + 16) || rst_cause !== 2'd1) begin
          errors++;
          $display("FAIL sim_hold_restart +%0d got %b cause %0d want %b cause 1", last_edge - s, reset_n_out[0], rst_cause, last_edge == s + 16);
        end
      end
    end
  endtask

  task automatic test_reset_mid_release();
    longint base, e;
    wdt_kick   = 1'b0;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    for (int k = 0, n = $urandom_range(16, 25); k < n; k++) tick();
    checks++;
    if (reset_n_out[0] !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_release_pre got %b busy %b want dom0=1 busy=1", reset_n_out, busy);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({reset_n_out, busy, rst_cause} !== {4'b0000, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL mid_release_reset got %b/%b/%0d want 0000/1/0", reset_n_out, busy, rst_cause);
    end
    reset = 1'b0;
    base  = t;
    for (int k = 0; k < 35; k++) begin
      tick();
      e = last_edge - base;
      checks++;
      if ({reset_n_out, busy, rst_cause} !== {exp_rst_n, exp_busy, m_cause}) begin
        errors++;
        $display("FAIL mid_seq edge %0d got %b/%b/%0d want %b/%b/%0d", e, reset_n_out, busy, rst_cause, exp_rst_n, exp_busy, m_cause);
      end
      if (e == 15 || e == 19 || e == 23 || e == 27) begin
        logic [N-1:0] want;
        want = (e == 15) ? 4'b0001 : (e == 19) ? 4'b0011 : (e == 23) ? 4'b0111 : 4'b1111;
        checks++;
        if (reset_n_out !== want) begin
          errors++;
          $display("FAIL mid_edge%0d got %b want %b", e, reset_n_out, want);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_por_release();
    test_sw_reset();
    test_ext_stretch();
    test_watchdog();
    test_simultaneous();
    test_reset_mid_release();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
